// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: word width, load/store
// encodings and the transaction state type.
package riscv_defines;

  localparam int unsigned WORD_WIDTH = 32;

  localparam logic [2:0] LOAD_NONE = 3'b000;
  localparam logic [2:0] LOAD_LB   = 3'b001;
  localparam logic [2:0] LOAD_LH   = 3'b010;
  localparam logic [2:0] LOAD_LW   = 3'b011;
  localparam logic [2:0] LOAD_LBU  = 3'b100;
  localparam logic [2:0] LOAD_LHU  = 3'b101;

  localparam logic [1:0] STORE_NONE = 2'b00;
  localparam logic [1:0] STORE_SB   = 2'b01;
  localparam logic [1:0] STORE_SH   = 2'b10;
  localparam logic [1:0] STORE_SW   = 2'b11;

  typedef enum logic [1:0] {
    LSU_IDLE        = 2'b00,
    LSU_REQ         = 2'b01,
    LSU_WAIT_RVALID = 2'b10
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store lane replication,
// load extraction/extension and misalignment detection.
module lsu_align
  import riscv_defines::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  load_type,
  input  logic [1:0]  store_type,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  logic       is_byte;
  logic       is_half;
  logic       is_word;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // A pending load decides the access size; otherwise the store does.
  always_comb begin
    is_byte = 1'b0;
    is_half = 1'b0;
    is_word = 1'b0;
    if (load_type != LOAD_NONE) begin
      is_byte = (load_type == LOAD_LB) || (load_type == LOAD_LBU);
      is_half = (load_type == LOAD_LH) || (load_type == LOAD_LHU);
      is_word = (load_type == LOAD_LW);
    end else begin
      is_byte = (store_type == STORE_SB);
      is_half = (store_type == STORE_SH);
      is_word = (store_type == STORE_SW);
    end
  end

  always_comb begin
    be = '0;
    if (is_byte)      be = 4'b0001 << off;
    else if (is_half) be = off[1] ? 4'b1100 : 4'b0011;
    else if (is_word) be = 4'b1111;
    misaligned = (is_half && off[0]) || (is_word && (off != 2'b00));
  end

  always_comb begin
    case (store_type)
      STORE_SB: wdata_lane = {4{wdata[7:0]}};
      STORE_SH: wdata_lane = {2{wdata[15:0]}};
      STORE_SW: wdata_lane = wdata;
      default:  wdata_lane = '0;
    endcase
  end

  always_comb begin
    byte_sel = rdata[8*off +: 8];
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    case (load_type)
      LOAD_LB:  rdata_ext = {{24{byte_sel[7]}}, byte_sel};
      LOAD_LBU: rdata_ext = {24'b0, byte_sel};
      LOAD_LH:  rdata_ext = {{16{half_sel[15]}}, half_sel};
      LOAD_LHU: rdata_ext = {16'b0, half_sel};
      LOAD_LW:  rdata_ext = rdata;
      default:  rdata_ext = '0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one outstanding req/gnt/rvalid transaction to the data
// memory port, with lane alignment of store data and load extension.
module lsu
  import riscv_defines::*;
#(
  parameter int unsigned WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  op_valid_i,
  input  logic [2:0]            load_type_i,
  input  logic [1:0]            store_type_i,
  input  logic [WORD_WIDTH-1:0] addr_i,
  input  logic [WORD_WIDTH-1:0] wdata_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [WORD_WIDTH-1:0] rdata_o,
  output logic                  error_o,
  output logic                  data_req_o,
  output logic [WORD_WIDTH-1:0] data_addr_o,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  output logic [WORD_WIDTH-1:0] data_wdata_o,
  input  logic [WORD_WIDTH-1:0] data_rdata_i,
  input  logic                  data_rvalid_i,
  input  logic                  data_gnt_i
);

  lsu_state_t state;
  logic [1:0] off_q;
  logic [2:0] load_q;

  logic [1:0]  a_off;
  logic [2:0]  a_load;
  logic [3:0]  be;
  logic [31:0] wdata_lane;
  logic [31:0] rdata_ext;
  logic        misaligned;
  logic        ld_nz, st_nz, bad_ld;
  logic        accept, reject;

  // In IDLE the aligner sees the incoming op; afterwards it sees the
  // latched offset/type so the response is extracted for the right access.
  always_comb begin
    a_off  = (state == LSU_IDLE) ? addr_i[1:0] : off_q;
    a_load = (state == LSU_IDLE) ? load_type_i : load_q;
  end

  lsu_align u_align (
    .off        (a_off),
    .load_type  (a_load),
    .store_type (store_type_i),
    .wdata      (wdata_i),
    .rdata      (data_rdata_i),
    .be         (be),
    .wdata_lane (wdata_lane),
    .rdata_ext  (rdata_ext),
    .misaligned (misaligned)
  );

  always_comb begin
    ld_nz  = (load_type_i != LOAD_NONE);
    st_nz  = (store_type_i != STORE_NONE);
    bad_ld = load_type_i[2] & load_type_i[1];
    accept = op_valid_i && (ld_nz ^ st_nz) && !bad_ld && !misaligned;
    reject = op_valid_i && ((ld_nz && st_nz) || bad_ld ||
                            ((ld_nz ^ st_nz) && misaligned));
  end

  assign busy_o     = (state != LSU_IDLE);
  assign data_req_o = (state == LSU_REQ);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= LSU_IDLE;
      off_q        <= '0;
      load_q       <= '0;
      done_o       <= 1'b0;
      error_o      <= 1'b0;
      rdata_o      <= '0;
      data_addr_o  <= '0;
      data_we_o    <= 1'b0;
      data_be_o    <= '0;
      data_wdata_o <= '0;
    end else begin
      done_o  <= 1'b0;
      error_o <= 1'b0;
      case (state)
        LSU_IDLE: begin
          if (accept) begin
            state        <= LSU_REQ;
            off_q        <= addr_i[1:0];
            load_q       <= load_type_i;
            data_addr_o  <= {addr_i[WORD_WIDTH-1:2], 2'b00};
            data_we_o    <= st_nz;
            data_be_o    <= be;
            data_wdata_o <= wdata_lane;
          end else if (reject) begin
            error_o <= 1'b1;
          end
        end
        LSU_REQ: begin
          if (data_gnt_i) state <= LSU_WAIT_RVALID;
        end
        LSU_WAIT_RVALID: begin
          if (data_rvalid_i) begin
            state  <= LSU_IDLE;
            done_o <= 1'b1;
            if (load_q != LOAD_NONE) rdata_o <= rdata_ext;
          end
        end
        default: state <= LSU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: directed ops push expected bus requests and
// completion events; monitors compare on the falling clock edge.
module tb_lsu;
  import riscv_defines::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [2:0]  load_type;
  logic [1:0]  store_type;
  logic [31:0] addr, wdata;
  logic        busy, done, error;
  logic [31:0] rdata_out;
  logic        req, we, gnt, rvalid;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  be;

  always #5 clk = ~clk;

  lsu #(.WORD_WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .op_valid_i   (op_valid),
    .load_type_i  (load_type),
    .store_type_i (store_type),
    .addr_i       (addr),
    .wdata_i      (wdata),
    .busy_o       (busy),
    .done_o       (done),
    .rdata_o      (rdata_out),
    .error_o      (error),
    .data_req_o   (req),
    .data_addr_o  (bus_addr),
    .data_we_o    (we),
    .data_be_o    (be),
    .data_wdata_o (bus_wdata),
    .data_rdata_i (bus_rdata),
    .data_rvalid_i(rvalid),
    .data_gnt_i   (gnt)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    bit          is_err;
    logic [31:0] rdata;
  } ev_t;

  req_t reqq[$];
  ev_t  evq[$];
  ev_t  mon_ev;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bus-side monitor: every request cycle must match the front expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (req) begin
        if (reqq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_req: got data_req_o=1 expected 0 (addr %h)", bus_addr);
        end else begin
          chk("req_addr", bus_addr, reqq[0].addr);
          chk("req_be", 32'(be), 32'(reqq[0].be));
          chk("req_we", 32'(we), 32'(reqq[0].we));
          if (reqq[0].we) chk("req_wdata", bus_wdata, reqq[0].wdata);
          chk("busy_in_req", 32'(busy), 32'd1);
          if (gnt) void'(reqq.pop_front());
        end
      end
      if (done || error) begin
        if (evq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got done=%0b error=%0b expected none", done, error);
        end else begin
          mon_ev = evq.pop_front();
          chk("event_error", 32'(error), 32'(mon_ev.is_err));
          chk("event_done", 32'(done), 32'(!mon_ev.is_err));
          if (!mon_ev.is_err) chk("rdata", rdata_out, mon_ev.rdata);
          chk("busy_at_event", 32'(busy), 32'd0);
        end
      end
    end
  end

  task automatic drain();
    int n = 0;
    while ((evq.size() != 0 || reqq.size() != 0) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (evq.size() != 0 || reqq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d events %0d reqs pending expected 0", evq.size(), reqq.size());
      evq.delete();
      reqq.delete();
    end
    @(posedge clk); #1;
  endtask

  // Called at posedge+1. gdelay = cycles gnt is withheld in REQ.
  task automatic do_op(input logic [2:0] lt, input logic [1:0] st,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rd, input int gdelay,
                       input bit intrude, input bit is_err,
                       input logic [31:0] exp_addr, input logic [3:0] exp_be,
                       input logic [31:0] exp_wd, input logic [31:0] exp_rd);
    ev_t  e;
    req_t r;
    e.is_err = is_err;
    e.rdata  = exp_rd;
    evq.push_back(e);
    if (!is_err) begin
      r.addr  = exp_addr;
      r.be    = exp_be;
      r.we    = (st != STORE_NONE);
      r.wdata = exp_wd;
      reqq.push_back(r);
    end
    op_valid = 1'b1; load_type = lt; store_type = st; addr = a; wdata = wd;
    @(posedge clk); #1;
    op_valid = 1'b0; load_type = LOAD_NONE; store_type = STORE_NONE;
    if (!is_err) begin
      for (int i = 0; i < gdelay; i++) begin
        if (intrude && i == 1) begin
          op_valid = 1'b1; load_type = LOAD_LW; addr = 32'h0000_0500;
        end else begin
          op_valid = 1'b0; load_type = LOAD_NONE;
        end
        @(posedge clk); #1;
      end
      op_valid = 1'b0; load_type = LOAD_NONE;
      gnt = 1'b1;
      @(posedge clk); #1;
      gnt = 1'b0;
      rvalid = 1'b1; bus_rdata = rd;
      @(posedge clk); #1;
      rvalid = 1'b0;
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; op_valid = 1'b0; load_type = '0; store_type = '0;
    addr = '0; wdata = '0; gnt = 1'b0; rvalid = 1'b0; bus_rdata = '0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_be", 32'(be), 32'd0);
    chk("rst_rdata", rdata_out, 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    //    load      store     addr          wdata         rdata         gd in er  exp_addr      be       exp_wdata     exp_rdata
    do_op(LOAD_NONE, STORE_SW, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        1, 0, 0, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0000);
    do_op(LOAD_LB,   STORE_NONE, 32'h0000_0203, 32'h0,      32'h80FF_1234, 0, 0, 0, 32'h0000_0200, 4'b1000, 32'h0,         32'hFFFF_FF80);
    do_op(LOAD_LBU,  STORE_NONE, 32'h0000_0203, 32'h0,      32'h80FF_1234, 0, 0, 0, 32'h0000_0200, 4'b1000, 32'h0,         32'h0000_0080);
    do_op(LOAD_LB,   STORE_NONE, 32'h0000_0201, 32'h0,      32'h0000_7F00, 2, 0, 0, 32'h0000_0200, 4'b0010, 32'h0,         32'h0000_007F);
    do_op(LOAD_LH,   STORE_NONE, 32'h0000_0202, 32'h0,      32'h9ABC_5678, 0, 0, 0, 32'h0000_0200, 4'b1100, 32'h0,         32'hFFFF_9ABC);
    do_op(LOAD_LHU,  STORE_NONE, 32'h0000_0202, 32'h0,      32'h9ABC_5678, 0, 0, 0, 32'h0000_0200, 4'b1100, 32'h0,         32'h0000_9ABC);
    do_op(LOAD_LH,   STORE_NONE, 32'h0000_0200, 32'h0,      32'h9ABC_5678, 0, 0, 0, 32'h0000_0200, 4'b0011, 32'h0,         32'h0000_5678);
    do_op(LOAD_NONE, STORE_SH, 32'h0000_0301, 32'h1234,     32'h0,         0, 0, 1, 32'h0,         4'b0000, 32'h0,         32'h0);
    do_op(LOAD_LW,   STORE_SW, 32'h0000_0000, 32'h1,        32'h0,         0, 0, 1, 32'h0,         4'b0000, 32'h0,         32'h0);
    do_op(3'b110,    STORE_NONE, 32'h0000_0000, 32'h0,      32'h0,         0, 0, 1, 32'h0,         4'b0000, 32'h0,         32'h0);
    do_op(LOAD_LW,   STORE_NONE, 32'h0000_0102, 32'h0,      32'h0,         0, 0, 1, 32'h0,         4'b0000, 32'h0,         32'h0);
    do_op(LOAD_NONE, STORE_SB, 32'h0000_0001, 32'h0000_00A5, 32'h0,        5, 1, 0, 32'h0000_0000, 4'b0010, 32'hA5A5_A5A5, 32'h0000_5678);
    do_op(LOAD_NONE, STORE_SH, 32'h0000_0002, 32'h0000_1234, 32'h0,        0, 0, 0, 32'h0000_0000, 4'b1100, 32'h1234_1234, 32'h0000_5678);
    do_op(LOAD_LW,   STORE_NONE, 32'h0000_0010, 32'h0,      32'h1357_9BDF, 1, 0, 0, 32'h0000_0010, 4'b1111, 32'h0,         32'h1357_9BDF);

    // Reset while waiting for rvalid; the late response must be dropped.
    begin
      req_t r;
      r.addr = 32'h0000_0400; r.be = 4'b1111; r.we = 1'b0; r.wdata = '0;
      reqq.push_back(r);
      op_valid = 1'b1; load_type = LOAD_LW; store_type = STORE_NONE; addr = 32'h0000_0400;
      @(posedge clk); #1;
      op_valid = 1'b0; load_type = LOAD_NONE;
      gnt = 1'b1;
      @(posedge clk); #1;
      gnt = 1'b0;
      rst = 1'b1;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_req", 32'(req), 32'd0);
      chk("midrst_addr", bus_addr, 32'd0);
      chk("midrst_be", 32'(be), 32'd0);
      chk("midrst_rdata", rdata_out, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      gnt = 1'b1;
      rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      gnt = 1'b0; rvalid = 1'b0;
      chk("late_rsp_done", 32'(done), 32'd0);
      chk("late_rsp_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      chk("late_rsp_done2", 32'(done), 32'd0);
      chk("late_rsp_rdata", rdata_out, 32'd0);
    end

    do_op(LOAD_LW,   STORE_NONE, 32'h0000_0020, 32'h0,      32'hCAFE_F00D, 0, 0, 0, 32'h0000_0020, 4'b1111, 32'h0,         32'hCAFE_F00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
Load/store unit between the writeback stage and the external data memory port. It accepts one memory operation per request from the pipeline and runs the req/gnt/rvalid handshake, keeping one transaction outstanding at most. It generates byte enables, lane-aligns store data, and extracts and sign- or zero-extends load data. While a transaction is in flight it asserts busy_o so that hazard control stalls the pipeline.

Parameters:
WORD_WIDTH, 32, data and address width; only 32 is supported.

Ports:
clk  in  1  core clock.
rst  in  1  asynchronous reset, active-high.
op_valid_i  in  1  operation request from the pipeline; sampled only in IDLE.
load_type_i  in  3  load encoding: 000 none, 001 LB, 010 LH, 011 LW, 100 LBU, 101 LHU; 110 and 111 are illegal.
store_type_i  in  2  store encoding: 00 none, 01 SB, 10 SH, 11 SW.
addr_i  in  32  byte address (ALU result).
wdata_i  in  32  store data (rs2), right-justified.
busy_o  out  1  transaction in flight; the pipeline stalls.
done_o  out  1  one-cycle pulse when the transaction completes.
rdata_o  out  32  extended load data; valid while done_o is high and held until the next done_o.
error_o  out  1  one-cycle pulse when an operation is rejected; no bus request is made.
data_req_o  out  1  memory request.
data_addr_o  out  32  word-aligned address {addr[31:2],2'b00}.
data_we_o  out  1  1 = store.
data_be_o  out  4  byte enables.
data_wdata_o  out  32  lane-replicated store data.
data_rdata_i  in  32  memory read data.
data_rvalid_i  in  1  response valid.
data_gnt_i  in  1  request accepted.

Behaviour:
- Reset (async, rst=1): state goes to IDLE. busy_o, done_o, error_o, data_req_o and data_we_o are 0. data_be_o is 0. rdata_o, data_addr_o and data_wdata_o are 0. Any response arriving after reset is ignored.
- FSM states: IDLE, REQ, WAIT_RVALID.
- IDLE:
  - A legal op is op_valid_i=1 with exactly one of load_type_i/store_type_i nonzero and a legal, aligned encoding.
  - A legal op latches address, type and data, then moves to REQ on the next edge.
  - Both types nonzero, load_type_i 110/111, or misalignment gives error_o=1 on the next cycle and the FSM stays in IDLE.
  - op_valid_i with both types zero is a no-op.
- Misalignment rules: a halfword access with addr[0]=1 is misaligned; a word access with addr[1:0]≠00 is misaligned.
- REQ:
  - data_req_o=1 and the data_* outputs are driven from the latched registers. They are stable until grant.
  - gnt=1 moves to WAIT_RVALID, and data_req_o drops on the next cycle.
  - data_rvalid_i is ignored in REQ; the earliest legal response comes the cycle after gnt.
- WAIT_RVALID:
  - On rvalid=1, rdata_o is registered with the extended value, done_o=1 on the next cycle, and the FSM returns to IDLE.
  - Stores also wait for rvalid; their rdata_o is unchanged.
- busy_o = (state≠IDLE).
- Because done_o appears in the cycle the FSM is back in IDLE, a new op can be accepted in the same cycle done_o is high.
- Minimum latency is 3 cycles from accept to done_o: accept edge, then REQ with gnt, then WAIT_RVALID with rvalid, then done_o.
- Byte enables, with off = addr[1:0]:
  - SB/LB/LBU: 4'b0001<<off.
  - SH/LH/LHU: addr[1] ? 1100 : 0011.
  - SW/LW: 1111.
- Store data: SB replicates wdata[7:0] into all 4 lanes; SH replicates wdata[15:0] into both halves; SW passes wdata unchanged.
- Load extract:
  - Byte B = rdata[8*off +: 8]; LB sign-extends B, LBU zero-extends B.
  - Halfword H = rdata[16*addr[1] +: 16]; LH sign-extends H, LHU zero-extends H.
  - LW passes rdata unchanged.
- Reset mid-transaction: data_req_o drops asynchronously. A grant or rvalid after reset release is ignored, because the FSM is in IDLE.

Decomposition:
- Package riscv_defines holds WORD_WIDTH, the LOAD_* (3-bit) and STORE_* (2-bit) encodings, and the lsu_state_t enum.
- Sub-module lsu_align is purely combinational: it generates be, replicates wdata, extracts/extends rdata and detects misalignment. It is instantiated once in lsu.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, gnt in the 2nd REQ cycle, rvalid 1 cycle later -> addr_o=0x100, be=1111, we=1, wdata=0xDEADBEEF; done_o one cycle; busy_o high throughout.
- LB addr=0x203, rdata=0x80FF1234 -> be=1000; rdata_o=0xFFFFFF80. LBU at the same address -> 0x00000080.
- LH addr=0x202, rdata=0x9ABC5678 -> be=1100; rdata_o=0xFFFF9ABC. LHU -> 0x00009ABC.
- SH addr=0x301 -> error_o pulse, data_req_o never asserted. Load and store both nonzero -> error_o pulse.
- SB addr=0x1, wdata=0x000000A5, gnt withheld 5 cycles -> data_req_o, addr, be=0010 and wdata=0xA5A5A5A5 held stable for all 5 cycles; a second op_valid_i during that time is ignored.
- rst asserted in WAIT_RVALID, then rvalid arrives after release -> all outputs 0 and no done_o; the next LW completes normally.
